// File: rtl/rc_tag_arbiter_pkg.sv
// Shared definitions for the RC read-tag arbiter: default sizes, completion
// status encodings and the completion-length-to-bytes helper.
package rc_tag_arbiter_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int NTAGS_DEF = 32;

  typedef enum logic [2:0] {
    CPL_SC = 3'd0,
    CPL_UR = 3'd1,
    CPL_CA = 3'd4
  } cpl_status_e;

  // A DW length of zero encodes the maximum payload of 1024 DW.
  function automatic logic [12:0] dwlen_to_bytes(input logic [9:0] dwlen);
    return (dwlen == 10'd0) ? 13'd4096 : {1'b0, dwlen, 2'b00};
  endfunction

endpackage

// File: rtl/rc_tag_arbiter_if.sv
// Request, RQ-path and completion-routing signals of the tag arbiter.
// The arbiter uses the master modport; its environment uses slave.
interface rc_tag_arbiter_if #(
  parameter int NREQ = 4,
  parameter int TW   = 5
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*10-1:0] req_dwlen;
  logic [NREQ-1:0]    req_ack;

  logic               rq_valid;
  logic               rq_ready;
  logic [7:0]         rq_tag;
  logic [1:0]         rq_owner;
  logic [9:0]         rq_dwlen;

  logic               cpl_valid;
  logic [7:0]         cpl_tag;
  logic [11:0]        cpl_bytecnt;
  logic [9:0]         cpl_dwlen;
  logic [2:0]         cpl_status;

  logic               route_valid;
  logic [1:0]         route_owner;
  logic               route_last;
  logic               cpl_err;
  logic [TW:0]        tags_free;

  modport master (
    input  req_valid, req_dwlen, rq_ready,
           cpl_valid, cpl_tag, cpl_bytecnt, cpl_dwlen, cpl_status,
    output req_ack, rq_valid, rq_tag, rq_owner, rq_dwlen,
           route_valid, route_owner, route_last, cpl_err, tags_free
  );

  modport slave (
    output req_valid, req_dwlen, rq_ready,
           cpl_valid, cpl_tag, cpl_bytecnt, cpl_dwlen, cpl_status,
    input  req_ack, rq_valid, rq_tag, rq_owner, rq_dwlen,
           route_valid, route_owner, route_last, cpl_err, tags_free
  );
endinterface

// File: rtl/rc_tag_free_list.sv
// Tag pool: busy bitmap, lowest-free-tag priority encoder and free counter.
// Allocation and release may happen in the same cycle on different tags.
module rc_tag_free_list
  import rc_tag_arbiter_pkg::*;
#(
  parameter int NTAGS = NTAGS_DEF,
  parameter int TW    = 5
) (
  input  logic             user_clk,
  input  logic             user_reset,
  input  logic             alloc,
  input  logic             free,
  input  logic [TW-1:0]    free_tag,
  output logic [TW-1:0]    next_tag,
  output logic             any_free,
  output logic [NTAGS-1:0] busy,
  output logic [TW:0]      tags_free
);

  logic [NTAGS-1:0] busy_next;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    next_tag = '0;
    for (int i = NTAGS - 1; i >= 0; i--) begin
      if (!busy[i]) next_tag = TW'(i);
    end
  end

  assign any_free = ~&busy;

  always_comb begin
    busy_next = busy;
    if (alloc) busy_next[next_tag] = 1'b1;
    if (free)  busy_next[free_tag] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      busy      <= '0;
      tags_free <= (TW+1)'(NTAGS);
    end else begin
      busy      <= busy_next;
      tags_free <= tags_free + (TW+1)'(free) - (TW+1)'(alloc);
    end
  end

endmodule

// File: rtl/rc_tag_arbiter.sv
// Round-robin read-request arbiter that allocates PCIe tags, presents tagged
// requests to the RQ path and routes RC completions back to their owner.
module rc_tag_arbiter
  import rc_tag_arbiter_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int NTAGS = NTAGS_DEF,
  parameter int TW    = 5
) (
  input  logic              user_clk,
  input  logic              user_reset,
  rc_tag_arbiter_if.master  bus
);

  localparam int         RRW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [8:0] NTAGS_W = 9'(NTAGS);

  logic [RRW-1:0]   rr;
  logic [RRW-1:0]   gnt_idx;
  logic [RRW-1:0]   scan_idx;
  logic [9:0]       gnt_dwlen;
  logic             grant;
  logic             can_grant;
  logic             any_free;
  logic [TW-1:0]    next_tag;
  logic [NTAGS-1:0] busy;
  logic [TW-1:0]    cpl_idx;
  logic             cpl_hit;
  logic             cpl_last;
  logic [1:0]       owner [NTAGS];

  rc_tag_free_list #(.NTAGS(NTAGS), .TW(TW)) u_free_list (
    .user_clk   (user_clk),
    .user_reset (user_reset),
    .alloc      (grant),
    .free       (cpl_last),
    .free_tag   (cpl_idx),
    .next_tag   (next_tag),
    .any_free   (any_free),
    .busy       (busy),
    .tags_free  (bus.tags_free)
  );

  // The output stage can take a new request if empty or draining this cycle.
  assign can_grant = any_free && (!bus.rq_valid || bus.rq_ready);

  // Scan from rr downward in priority; the last hit written is the closest to rr.
  always_comb begin
    grant    = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      scan_idx = RRW'((int'(rr) + i) % NREQ);
      if (bus.req_valid[scan_idx]) begin
        grant   = can_grant;
        gnt_idx = scan_idx;
      end
    end
  end

  always_comb begin
    gnt_dwlen = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == RRW'(i)) gnt_dwlen = bus.req_dwlen[10*i +: 10];
    end
  end

  assign cpl_idx  = bus.cpl_tag[TW-1:0];
  assign cpl_hit  = bus.cpl_valid && ({1'b0, bus.cpl_tag} < NTAGS_W) && busy[cpl_idx];
  assign cpl_last = cpl_hit && ((bus.cpl_status != CPL_SC) ||
                                ({1'b0, bus.cpl_bytecnt} <= dwlen_to_bytes(bus.cpl_dwlen)));

  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      rr              <= '0;
      bus.req_ack     <= '0;
      bus.rq_valid    <= 1'b0;
      bus.rq_tag      <= '0;
      bus.rq_owner    <= '0;
      bus.rq_dwlen    <= '0;
      bus.route_valid <= 1'b0;
      bus.route_owner <= '0;
      bus.route_last  <= 1'b0;
      bus.cpl_err     <= 1'b0;
      // NOTE: the owner table is small and must read as zero after reset, so it is reset like any register.
      for (int t = 0; t < NTAGS; t++) owner[t] <= '0;
    end else begin
      bus.req_ack <= grant ? (NREQ'(1) << gnt_idx) : '0;
      if (grant) begin
        bus.rq_valid    <= 1'b1;
        bus.rq_tag      <= 8'(next_tag);
        bus.rq_owner    <= 2'(gnt_idx);
        bus.rq_dwlen    <= gnt_dwlen;
        owner[next_tag] <= 2'(gnt_idx);
        rr              <= RRW'((int'(gnt_idx) + 1) % NREQ);
      end else if (bus.rq_ready) begin
        bus.rq_valid <= 1'b0;
      end

      bus.route_valid <= cpl_hit;
      bus.route_owner <= cpl_hit ? owner[cpl_idx] : 2'd0;
      bus.route_last  <= cpl_last;
      bus.cpl_err     <= bus.cpl_valid && !cpl_hit;
    end
  end

endmodule

// File: doc/rc_tag_arbiter.md
RC_TAG_ARBITER -- requirements
Module: rc_tag_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NREQ, 4, number of read requesters.
- NTAGS, 32, tag pool size (power of 2, max 256).
- TW, 5, tag width, log2(NTAGS).
REQ-002 Ports (name, direction, width, meaning):
- user_clk  in  1  sole clock.
- user_reset  in  1  reset, asynchronous, active-high.
- req_valid  in  NREQ  read request pending, per requester.
- req_dwlen  in  NREQ*10  request length in DW, requester i at bits [10i+9:10i].
- req_ack  out  NREQ  one-cycle pulse: request i accepted.
- rq_valid  out  1  tagged request to RQ path.
- rq_ready  in  1  RQ path accepts.
- rq_tag  out  8  allocated tag, zero-extended.
- rq_owner  out  2  requester index.
- rq_dwlen  out  10  request length.
- cpl_valid  in  1  RC completion header beat (SOP) present.
- cpl_tag  in  8  completion tag.
- cpl_bytecnt  in  12  remaining byte count.
- cpl_dwlen  in  10  completion payload DW.
- cpl_status  in  3  completion status.
- route_valid  out  1  routing decision valid.
- route_owner  out  2  requester owning the completion.
- route_last  out  1  final completion of the request; tag released.
- cpl_err  out  1  one-cycle pulse: unknown or idle tag.
- tags_free  out  TW+1  count of free tags.

Function
REQ-003 Tag state: busy bitmap of NTAGS bits plus an owner table (2 bits/tag).
REQ-004 Arbitration is round-robin over req_valid, starting at pointer rr.
- It runs only when at least one tag is free and the output stage is empty, or is being drained this cycle (rq_valid && rq_ready).
REQ-005 Grant to requester w in cycle N, all registered at edge N+1:
- req_ack[w]=1 for exactly one cycle.
- Output stage loads rq_valid=1, rq_tag, rq_owner=w and rq_dwlen.
- Tag busy bit is set and owner[tag]=w.
- rr becomes (w+1) mod NREQ.
REQ-006 Allocated tag is the lowest-index free tag.
REQ-007 rq_valid, rq_tag, rq_owner and rq_dwlen hold stable until rq_ready is sampled high; rq_valid then clears unless a new grant loads in the same cycle.
REQ-008 Completion lookup has 1-cycle latency.
- A cpl_valid in cycle N produces route_valid=1 at edge N+1, with route_owner=owner[cpl_tag].
REQ-009 route_last=1 when the tag is busy and any of these holds:
- cpl_status!=0;
- cpl_bytecnt<=cpl_dwlen*4, computed in 13 bits, with cpl_dwlen==0 meaning 1024.
REQ-010 On route_last the busy bit clears at edge N+1; the tag can be allocated from cycle N+1 onward.
REQ-011 cpl_err=1 (with route_valid=0) when cpl_tag>=NTAGS or the tag is not busy; state is unchanged.
REQ-012 Allocation and release in the same cycle are both applied, and tags_free is unchanged.
- The same tag cannot be both allocated and released, since allocation requires a free tag.
REQ-013 With tags_free==0, no grant occurs and req_ack stays 0; req_valid may stay asserted indefinitely.
REQ-014 tags_free always equals NTAGS minus popcount(busy).

Reset
REQ-015 Asynchronous assertion sets the following; deassertion is synchronous to user_clk:
- busy=0, owner=0, rr=0;
- rq_valid=0, rq_tag=0, rq_owner=0, rq_dwlen=0;
- req_ack=0, route_valid=0, route_owner=0, route_last=0, cpl_err=0;
- tags_free=NTAGS.
REQ-016 Reset mid-operation drops all outstanding tags. Completions arriving after reset for those tags raise cpl_err.

Structure
REQ-017 Shared package holds:
- NREQ and NTAGS defaults;
- completion status encodings (SC=0, UR=1, CA=4);
- the dwlen-to-bytes helper.
REQ-018 One sub-module, rc_tag_free_list, holds the busy bitmap, lowest-free priority encoder and tags_free counter.
- Its ports are alloc, free and free_tag, and its outputs are next_tag and any_free.

Verification
REQ-019 Reset, then req_valid=4'b1111 with rq_ready=1:
- req_ack pulses in order 0,1,2,3,0;
- rq_tag runs 0,1,2,3,4;
- tags_free drops 32->27.
REQ-020 Completion tag=2, bytecnt=64, dwlen=16, status=0: route_valid=1, route_owner=2, route_last=1; tag 2 is reused by the next grant.
REQ-021 Completion tag=1, bytecnt=128, dwlen=16: route_last=0 and tag 1 stays busy. A following completion with bytecnt=64 and dwlen=16 releases it.
REQ-022 Allocate all 32 tags: no req_ack while full. One release allows exactly one grant, which reuses the released tag number.
REQ-023 cpl_tag=40, or an idle tag 7: cpl_err pulses once, route_valid=0, tags_free is unchanged.
REQ-024 rq_ready=0 for 5 cycles with the output stage loaded: rq_tag is stable and no further req_ack. Assert user_reset mid-run: all outputs are zero asynchronously and tags_free=32.
